// File: rtl/bus_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_scan_pkg
//  Description : Shared constants and state encoding for the round-robin
//                bus scanner, the multiplexer wrapper and their benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_scan_pkg;

    localparam int          N_BUS    = 16;
    localparam int          SEL_W    = 5;
    localparam logic [4:0]  SEL_PARK = 5'd16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick16.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick16
//  Description : Combinational rotating priority encoder. Returns the first
//                set request bit at or after base, wrapping 15 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick16 (
    input  logic [15:0] req,
    input  logic [3:0]  base,
    output logic        found,
    output logic [3:0]  idx
);

    logic [15:0] w_rot;
    logic [3:0]  w_off;

    // Rotate so that bit 'base' lands at position 0; the doubled vector
    // makes the wrap-around free.
    assign w_rot = 16'({req, req} >> base);

    // Lowest set bit of the rotated vector is the distance from base.
    always_comb begin
        w_off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 4'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = base + w_off;

endmodule
`default_nettype wire

// File: rtl/bus_rr_scanner16.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_scanner16
//  Description : Round-robin scanner driving the select of a registered
//                16-way bus multiplexer. Picks a requesting bus, waits the
//                multiplexer latency, captures the word, acknowledges the
//                bus and offers the word downstream with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_scanner16
    import bus_scan_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUX_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BUS-1:0]  req,
    input  logic [DATA_W-1:0] mux_data,
    output logic [SEL_W-1:0]  sel,
    output logic [N_BUS-1:0]  ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [2:0]       c_MUX_LAT = 3'(MUX_LAT);
    localparam logic [N_BUS-1:0] c_ONE     = {{(N_BUS-1){1'b0}}, 1'b1};

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [3:0]        r_gnt;
    logic [3:0]        r_ptr;
    logic [2:0]        r_cnt;
    logic [N_BUS-1:0]  r_ack;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    logic              w_found;
    logic [3:0]        w_idx;
    logic              w_load;
    logic              w_cap;
    logic              w_done;

    rr_pick16 u_pick (
        .req   (req),
        .base  (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and one-cycle action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SETTLE;
                    w_load      = 1'b1;
                end
            end
            SETTLE: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = HOLD;
                w_cap       = 1'b1;
            end
            HOLD: begin
                if (r_valid && out_ready) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, select, settle counter and pointer. The pointer only moves on
    // a completed handshake so a stalled word never loses its turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt <= 4'd0;
            r_sel <= SEL_PARK;
            r_cnt <= 3'd0;
            r_ptr <= 4'd0;
        end else begin
            if (w_load) begin
                r_gnt <= w_idx;
                r_sel <= {1'b0, w_idx};
                r_cnt <= c_MUX_LAT;
            end else if (r_state == SETTLE) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_done) begin
                r_sel <= SEL_PARK;
                r_ptr <= r_gnt + 4'd1;
            end
        end
    end

    // Output word, valid flag and the single-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            if (w_cap) begin
                r_data  <= mux_data;
                r_valid <= 1'b1;
                r_ack   <= c_ONE << r_gnt;
            end else if (w_done) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sel        = r_sel;
    assign ack        = r_ack;
    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
